// File: rtl/instr_encode.sv
// Command-to-instruction encoder: queues host commands in a small FIFO, rejects illegal
// opcodes, and issues encoded instructions to the fetch/decode path. After issuing a
// start-type instruction it waits for the control unit to report completion.
module instr_encode #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd_op,
    input  logic [27:0]              cmd_data,
    output logic                     cmd_ready,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     proc_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_illegal,
    output logic [7:0]               err_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [30:0]       mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_illegal_q, err_illegal_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              accept;
    logic              op_legal;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [30:0]       head;

    function automatic logic is_start(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b100) || (op == 3'b101);
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Handshake decode; cmd_ready depends on stored occupancy only.
    always_comb begin
        cmd_ready  = (level_q < LvlW'(DEPTH));
        accept     = cmd_valid && cmd_ready;
        op_legal   = is_legal(cmd_op);
        push       = accept && op_legal;
        fifo_empty = (level_q == '0);
        head       = mem_q[rd_ptr_q];
    end

    // Issue FSM next-state and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (instr_ready) begin
                    if (is_start(instr_q[30:28])) begin
                        state_d = StWait;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWait: begin
                if (proc_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pointer, occupancy, output register and error counter next state.
    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d       = level_q;
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LvlW'(1);
        end
        instr_d       = pop ? {1'b0, head} : instr_q;
        err_illegal_d = accept && !op_legal;
        err_cnt_d     = err_cnt_q;
        if (accept && !op_legal && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Control and status state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            instr_q       <= '0;
            err_illegal_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            instr_q       <= instr_d;
            err_illegal_q <= err_illegal_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // FIFO storage; emptiness is tracked by level, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_data};
        end
    end

    assign instr       = instr_q;
    assign instr_valid = (state_q == StIssue);
    assign busy        = (state_q == StWait);
    assign level       = level_q;
    assign err_illegal = err_illegal_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  host command present.
REQ-005 cmd_op  in  3  command opcode.
REQ-006 cmd_data  in  28  command payload.
REQ-007 cmd_ready  out  1  block can accept a command this cycle.
REQ-008 instr  out  32  encoded instruction to the fetch/decode path.
REQ-009 instr_valid  out  1  instr is valid.
REQ-010 instr_ready  in  1  fetch/decode path consumes instr this cycle.
REQ-011 proc_done  in  1  one-cycle pulse from the control unit: the last start-type command has completed.
REQ-012 busy  out  1  waiting for proc_done.
REQ-013 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 err_illegal  out  1  one-cycle pulse: illegal opcode rejected.
REQ-015 err_cnt  out  8  saturating count of rejected commands.

Function
REQ-016 Legal opcodes: 000 (write reg 0 and start processing), 001 and 010 (register writes), 100 (RDN load start), 101 (DNN load start).
REQ-017 Illegal opcodes: 011, 110, 111.
REQ-018 Start-type opcodes: 000, 100, 101.
REQ-019 Encoding: instr[31]=0, instr[30:28]=op, instr[27:0]=data.
REQ-020 cmd_ready = (level < DEPTH); combinational from state only, never from cmd_valid.
REQ-021 Accept = cmd_valid && cmd_ready; a legal accepted command is enqueued at that edge.
REQ-022 An illegal accepted command is not enqueued; err_illegal pulses high the following cycle.
REQ-023 Each illegal accept increments err_cnt, which saturates at 255.
REQ-024 The FIFO preserves command order; write pointer and read pointer wrap modulo DEPTH.
REQ-025 FSM states: IDLE, ISSUE, WAIT.
REQ-026 IDLE: instr_valid=0; if FIFO non-empty, pop the head into the output register and go to ISSUE (instr_valid high the next cycle).
REQ-027 ISSUE: instr_valid=1; instr and instr_valid hold stable until instr_ready=1.
REQ-028 ISSUE handshake on a start-type opcode: go to WAIT; instr_valid=0 next cycle.
REQ-029 ISSUE handshake on a non-start opcode, FIFO non-empty: pop the next entry and stay in ISSUE (one instruction per cycle throughput).
REQ-030 ISSUE handshake on a non-start opcode, FIFO empty: go to IDLE.
REQ-031 WAIT: busy=1 and instr_valid=0; enqueueing continues; on proc_done go to IDLE.
REQ-032 proc_done outside WAIT is ignored, including a pulse in the same cycle as the start-type handshake.
REQ-033 Latency: a legal command accepted into an empty FIFO in IDLE at cycle N appears on instr_valid at N+2.
REQ-034 Simultaneous enqueue and dequeue: level is unchanged; a full FIFO still drops cmd_ready (no pass-through).

Reset
REQ-035 Asserting rst immediately forces: state=IDLE, FIFO empty, level=0, instr=0, instr_valid=0, busy=0, err_illegal=0, err_cnt=0, cmd_ready=1.
REQ-036 Reset mid-operation discards queued and in-flight commands; no instruction is emitted until new commands are accepted after deassertion.

Verification
REQ-037 Scenario 1: push op 001, data 0x0000ABC, instr_ready held 1 -> instr=0x10000ABC valid at N+2 for exactly one cycle; FSM returns to IDLE.
REQ-038 Scenario 2: push ops 001, 010, 100, 001 back-to-back, instr_ready held 1 -> three consecutive instructions; busy=1 after op 100; the fourth instruction is issued only 2 cycles after a proc_done pulse.
REQ-039 Scenario 3: push op 011 -> cmd accepted, no instruction issued, err_illegal pulses once, err_cnt=1; 300 illegal pushes -> err_cnt=255.
REQ-040 Scenario 4: instr_ready held 0, push DEPTH+2 legal commands -> cmd_ready=0 once level=DEPTH (one entry in the output register); instr stable; all commands drain in order once instr_ready=1.
REQ-041 Scenario 5: proc_done pulsed in IDLE and coincident with the op 101 handshake -> busy stays 1 until a later pulse.
REQ-042 Scenario 6: assert rst while in WAIT with 3 entries queued -> all outputs at reset values asynchronously; no stale instruction issued after release.
